cla_pipe_adder: RTL

- Pipelined multi-word adder built from 4-bit carry-lookahead groups.
- Each pipeline stage adds SLICE_W bits:
  - generates per-bit propagate/generate;
  - resolves carries through 4-bit lookahead groups rippled across the slice;
  - registers the partial sum and carry into the next stage.
- Sits in the datapath between operand registers and the ALU result mux.
- valid/ready handshake on both sides with full backpressure.

---
 rtl/cla_pipe_pkg.sv | 32 +++
 rtl/cla_pipe_slice.sv | 50 +++++
 rtl/cla_pipe_adder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cla_pipe_pkg.sv
// Purpose: shared types and the 4-bit carry-lookahead group function for cla_pipe_adder.
// Latency: n/a (package, combinational helpers only).
// Backpressure: n/a.
// Contents: GROUP_W, pg_t (per-bit propagate/generate of one group), cla_group().
package cla_pipe_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] g;
    } pg_t;

    // Returns carries c[0..4] of one group; c[0] is the group carry-in.
    // Every carry is written as a flat sum of products so no carry waits
    // on a lower one inside the group.
    function automatic logic [GROUP_W:0] cla_group(input pg_t pg, input logic ci);
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] g;
        logic [GROUP_W:0]   c;
        p    = pg.p;
        g    = pg.g;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/cla_pipe_slice.sv
// Purpose: SLICE_W-bit adder slice built from rippled 4-bit lookahead groups.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the owning pipeline stage decides when results are captured.
// Ports: a/b slice operands, cin slice carry-in, s slice sum,
//        cout carry out of the slice MSB, c_msb carry into the slice MSB.
module cla_pipe_slice
    import cla_pipe_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c_msb
);

    localparam int NG = SLICE_W / GROUP_W;

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    pg_t                pg;
    logic [GROUP_W:0]   gc;
    logic               carry;

    assign p = a ^ b;
    assign g = a & b;

    // Groups are evaluated in order; each group's top carry feeds the next.
    always_comb begin
        s     = '0;
        c_msb = 1'b0;
        pg    = '0;
        gc    = '0;
        carry = cin;
        for (int j = 0; j < NG; j++) begin
            pg.p = p[j*GROUP_W +: GROUP_W];
            pg.g = g[j*GROUP_W +: GROUP_W];
            gc   = cla_group(pg, carry);
            s[j*GROUP_W +: GROUP_W] = pg.p ^ gc[GROUP_W-1:0];
            if (j == NG - 1) begin
                c_msb = gc[GROUP_W-1];
            end
            carry = gc[GROUP_W];
        end
        cout = carry;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Purpose: pipelined WIDTH-bit adder, one SLICE_W-bit lookahead slice per stage.
// Latency: STAGES = WIDTH/SLICE_W cycles, 1 beat/cycle throughput.
// Backpressure: whole pipe stalls when out_valid & !out_ready; in_ready = !out_valid | out_ready.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/a/b/cin operand side,
//        out_valid/out_ready/sum/cout/ovf result side.
// Optional: CLA_PIPE_SUB_EN adds input sub (1 -> a - b, cin ignored).
// WIDTH must be a multiple of SLICE_W and SLICE_W a multiple of 4.
module cla_pipe_adder
    import cla_pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SLICE_W;

    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE_W{1'b1}});

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv;

`ifdef CLA_PIPE_SUB_EN
    // Two's-complement subtract: invert b and force the carry-in.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    // Stage registers: operands travel with the beat so later stages can
    // add their slice; s_q accumulates the sum bits resolved so far.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] vld_q;
    logic              ovf_q;

    // Per-stage combinational inputs and slice results.
    logic [WIDTH-1:0]   st_a  [STAGES];
    logic [WIDTH-1:0]   st_b  [STAGES];
    logic [WIDTH-1:0]   st_s  [STAGES];
    logic [WIDTH-1:0]   s_nx  [STAGES];
    logic [SLICE_W-1:0] sl_s  [STAGES];
    logic [STAGES-1:0]  st_c;
    logic [STAGES-1:0]  st_v;
    logic [STAGES-1:0]  sl_co;
    logic [STAGES-1:0]  sl_cm;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_a[k] = a;
            assign st_b[k] = b_eff;
            assign st_s[k] = '0;
            assign st_c[k] = c_eff;
            assign st_v[k] = in_valid;
        end else begin : g_rest
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_s[k] = s_q[k-1];
            assign st_c[k] = c_q[k-1];
            assign st_v[k] = vld_q[k-1];
        end

        cla_pipe_slice #(
            .SLICE_W (SLICE_W)
        ) u_slice (
            .a     (st_a[k][k*SLICE_W +: SLICE_W]),
            .b     (st_b[k][k*SLICE_W +: SLICE_W]),
            .cin   (st_c[k]),
            .s     (sl_s[k]),
            .cout  (sl_co[k]),
            .c_msb (sl_cm[k])
        );

        // Splice this stage's slice into the running sum.
        assign s_nx[k] = (st_s[k] & ~(SLICE_MASK << (k*SLICE_W)))
                       | (WIDTH'(sl_s[k]) << (k*SLICE_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= st_v;
            c_q   <= sl_co;
            // c[WIDTH] ^ c[WIDTH-1], both produced by the last slice.
            ovf_q <= sl_co[STAGES-1] ^ sl_cm[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                s_q[k] <= s_nx[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
